// File: rtl/tlb_assoc.sv
// Fully associative TLB with ASID/global tagging, one-cycle lookup, and a
// sequential invalidate walk that blocks lookups and writes while it runs.
module tlb_assoc #(
    parameter int ENTRIES = 8,
    parameter int ASID_W  = 6,
    parameter int VPN_W   = 8,
    parameter int PFN_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_valid,
    input  logic [ASID_W-1:0] lk_asid,
    input  logic [VPN_W-1:0]  lk_vpn,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [PFN_W-1:0]  rsp_pfn,
    input  logic              wr_en,
    input  logic [ASID_W-1:0] wr_asid,
    input  logic [VPN_W-1:0]  wr_vpn,
    input  logic [PFN_W-1:0]  wr_pfn,
    input  logic              wr_global,
    input  logic              inv_req,
    input  logic              inv_all,
    input  logic [ASID_W-1:0] inv_asid,
    output logic              busy
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t state_r, state_nxt_s;

    logic [ENTRIES-1:0] v_r;
    logic [ENTRIES-1:0] g_r;
    logic [ASID_W-1:0]  asid_r [ENTRIES];
    logic [VPN_W-1:0]   vpn_r  [ENTRIES];
    logic [PFN_W-1:0]   pfn_r  [ENTRIES];

    logic [IDX_W-1:0]   rr_r;
    logic [IDX_W-1:0]   idx_r;
    logic               inv_all_r;
    logic [ASID_W-1:0]  inv_asid_r;

    logic               rsp_valid_r;
    logic               rsp_hit_r;
    logic [PFN_W-1:0]   rsp_pfn_r;

    logic [ENTRIES-1:0] lk_match_s;
    logic               lk_hit_s;
    logic [PFN_W-1:0]   lk_pfn_s;
    logic [ENTRIES-1:0] wr_match_s;
    logic [ENTRIES-1:0] free_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               walking_s;
    logic               start_walk_s;
    logic               wr_go_s;
    logic               replace_s;
    logic               inv_hit_s;
    logic               rsp_hit_nxt_s;

    assign walking_s    = (state_r == WALK);
    assign start_walk_s = (state_r == IDLE) && inv_req;
    assign wr_go_s      = (state_r == IDLE) && !inv_req && wr_en;
    assign inv_hit_s    = inv_all_r || (!g_r[idx_r] && (asid_r[idx_r] == inv_asid_r));

    // Lookup match, lowest matching index supplies the frame
    always_comb begin
        lk_match_s = '0;
        lk_pfn_s   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match_s[i] = v_r[i] && (vpn_r[i] == lk_vpn) && (g_r[i] || (asid_r[i] == lk_asid));
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            lk_pfn_s = lk_match_s[i] ? pfn_r[i] : lk_pfn_s;
        end
        lk_hit_s = |lk_match_s;
    end

    // Write slot selection: matching entry, else lowest free, else round-robin victim
    always_comb begin
        wr_match_s = '0;
        free_s     = ~v_r;
        wr_idx_s   = rr_r;
        for (int i = 0; i < ENTRIES; i++) begin
            wr_match_s[i] = v_r[i] && (vpn_r[i] == wr_vpn) && (g_r[i] || (asid_r[i] == wr_asid));
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            wr_idx_s = free_s[i] ? IDX_W'(i) : wr_idx_s;
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            wr_idx_s = wr_match_s[i] ? IDX_W'(i) : wr_idx_s;
        end
        replace_s = wr_go_s && !(|wr_match_s) && !(|free_s);
    end

    // Invalidate FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (inv_req) state_nxt_s = WALK;
                else         state_nxt_s = IDLE;
            end
            WALK: begin
                if (idx_r == IDX_W'(ENTRIES - 1)) state_nxt_s = IDLE;
                else                              state_nxt_s = WALK;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Invalidate FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Valid bits: set on write, cleared by the walk
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r <= '0;
        end else if (wr_go_s) begin
            v_r[wr_idx_s] <= 1'b1;
        end else if (walking_s && inv_hit_s) begin
            v_r[idx_r] <= 1'b0;
        end
    end

    // Entry payload, never reset
    always_ff @(posedge clk) begin
        if (wr_go_s) begin
            g_r[wr_idx_s]    <= wr_global;
            asid_r[wr_idx_s] <= wr_asid;
            vpn_r[wr_idx_s]  <= wr_vpn;
            pfn_r[wr_idx_s]  <= wr_pfn;
        end
    end

    // A walk in progress forces every lookup to miss
    assign rsp_hit_nxt_s = lk_valid && !walking_s && lk_hit_s;

    // Replacement pointer, walk index, latched invalidate operands, response
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_r        <= '0;
            idx_r       <= '0;
            inv_all_r   <= 1'b0;
            inv_asid_r  <= '0;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_pfn_r   <= '0;
        end else begin
            rsp_valid_r <= lk_valid;
            rsp_hit_r   <= rsp_hit_nxt_s;
            rsp_pfn_r   <= rsp_hit_nxt_s ? lk_pfn_s : {PFN_W{1'b0}};
            if (start_walk_s) begin
                inv_all_r  <= inv_all;
                inv_asid_r <= inv_asid;
                idx_r      <= '0;
            end else if (walking_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
            if (replace_s) begin
                rr_r <= rr_r + IDX_W'(1);
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_hit   = rsp_hit_r;
    assign rsp_pfn   = rsp_pfn_r;
    assign busy      = walking_s;

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: directed scenarios then random traffic,
// checked against an entry-list reference model.
module tb_tlb_assoc;

    localparam int N = 8;

    logic       clk;
    logic       reset;
    logic       lk_valid;
    logic [5:0] lk_asid;
    logic [7:0] lk_vpn;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [7:0] rsp_pfn;
    logic       wr_en;
    logic [5:0] wr_asid;
    logic [7:0] wr_vpn;
    logic [7:0] wr_pfn;
    logic       wr_global;
    logic       inv_req;
    logic       inv_all;
    logic [5:0] inv_asid;
    logic       busy;

    tlb_assoc #(.ENTRIES(N), .ASID_W(6), .VPN_W(8), .PFN_W(8)) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_asid(lk_asid), .lk_vpn(lk_vpn),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_pfn(rsp_pfn),
        .wr_en(wr_en), .wr_asid(wr_asid), .wr_vpn(wr_vpn), .wr_pfn(wr_pfn),
        .wr_global(wr_global), .inv_req(inv_req), .inv_all(inv_all),
        .inv_asid(inv_asid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       hit;
        bit [7:0] pfn;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   model_known = 1'b0;

    // Reference model: plain list of entries plus pending-invalidate countdown
    bit       mv[N];
    bit       mg[N];
    bit [5:0] ma[N];
    bit [7:0] mvpn[N];
    bit [7:0] mpfn[N];
    int       mrr;
    int       walk_left;
    bit       pend_all;
    bit [5:0] pend_asid;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic m_lookup(input bit [5:0] a, input bit [7:0] vp, output bit hit, output bit [7:0] pf);
        hit = 1'b0;
        pf  = 8'h00;
        if (walk_left == 0) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && mv[i] && mvpn[i] == vp && (mg[i] || ma[i] == a)) begin
                    hit = 1'b1;
                    pf  = mpfn[i];
                end
            end
        end
    endtask

    task automatic m_write(input bit [5:0] a, input bit [7:0] vp, input bit [7:0] pf, input bit g);
        int slot;
        slot = -1;
        for (int i = 0; i < N; i++)
            if (slot < 0 && mv[i] && mvpn[i] == vp && (mg[i] || ma[i] == a)) slot = i;
        for (int i = 0; i < N; i++)
            if (slot < 0 && !mv[i]) slot = i;
        if (slot < 0) begin
            slot = mrr;
            mrr  = (mrr + 1) % N;
        end
        mv[slot] = 1'b1; mg[slot] = g; ma[slot] = a; mvpn[slot] = vp; mpfn[slot] = pf;
    endtask

    task automatic drive(input bit r, input bit lkv, input bit [5:0] la, input bit [7:0] lv,
                         input bit we, input bit [5:0] wa, input bit [7:0] wv, input bit [7:0] wp,
                         input bit wg, input bit ir, input bit ia, input bit [5:0] iasid);
        exp_t e;
        bit   h;
        bit [7:0] p;
        @(negedge clk);
        if (model_known) begin
            n_checks++;
            if (busy !== (walk_left > 0)) begin
                n_fail++;
                $display("FAIL busy cyc=%0d: got %b, expected %b", cyc, busy, walk_left > 0);
            end
        end
        reset = r; lk_valid = lkv; lk_asid = la; lk_vpn = lv;
        wr_en = we; wr_asid = wa; wr_vpn = wv; wr_pfn = wp; wr_global = wg;
        inv_req = ir; inv_all = ia; inv_asid = iasid;
        if (lkv && !r) begin
            m_lookup(la, lv, h, p);
            e.cyc = cyc; e.hit = h; e.pfn = p;
            sbq.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mrr = 0;
            walk_left = 0;
            model_known = 1'b1;
        end else if (walk_left > 0) begin
            walk_left--;
            if (walk_left == 0)
                for (int i = 0; i < N; i++)
                    if (pend_all || (!mg[i] && ma[i] == pend_asid)) mv[i] = 1'b0;
        end else if (ir) begin
            pend_all = ia; pend_asid = iasid; walk_left = N;
        end else if (we) begin
            m_write(wa, wv, wp, wg);
        end
    endtask

    task automatic idle();
        drive(0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00, 8'h00, 0, 0, 0, 6'd0);
    endtask
    task automatic rst();
        drive(1, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00, 8'h00, 0, 0, 0, 6'd0);
        mon_en = 1'b1;
    endtask
    task automatic wr(input bit [5:0] a, input bit [7:0] vp, input bit [7:0] pf, input bit g);
        drive(0, 0, 6'd0, 8'h00, 1, a, vp, pf, g, 0, 0, 6'd0);
    endtask
    task automatic lk(input bit [5:0] a, input bit [7:0] vp);
        drive(0, 1, a, vp, 0, 6'd0, 8'h00, 8'h00, 0, 0, 0, 6'd0);
    endtask
    task automatic inv(input bit ia, input bit [5:0] a);
        drive(0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00, 8'h00, 0, 1, ia, a);
    endtask

    // Monitor: every cycle, either the queued response is due or rsp_valid must be low
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_checks++;
            if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
                mon_e = sbq.pop_front();
                if (rsp_valid !== 1'b1 || rsp_hit !== mon_e.hit || rsp_pfn !== mon_e.pfn) begin
                    n_fail++;
                    $display("FAIL rsp cyc=%0d: got v=%b hit=%b pfn=%h, expected v=1 hit=%b pfn=%h",
                             cyc - 1, rsp_valid, rsp_hit, rsp_pfn, mon_e.hit, mon_e.pfn);
                end
            end else if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_idle cyc=%0d: got rsp_valid=%b, expected 0", cyc - 1, rsp_valid);
            end
        end
    end

    initial begin
        reset = 1'b1; lk_valid = 1'b0; lk_asid = '0; lk_vpn = '0;
        wr_en = 1'b0; wr_asid = '0; wr_vpn = '0; wr_pfn = '0; wr_global = 1'b0;
        inv_req = 1'b0; inv_all = 1'b0; inv_asid = '0;
        mrr = 0; walk_left = 0; pend_all = 1'b0; pend_asid = '0;
        for (int i = 0; i < N; i++) mv[i] = 1'b0;

        // Basic hit/miss by ASID
        rst(); idle();
        wr(6'd0, 8'hC9, 8'h02, 1'b0);
        lk(6'd0, 8'hC9);
        lk(6'd1, 8'hC9);

        // Global entry survives selective invalidate; walk blocks lookups and writes
        wr(6'd5, 8'h10, 8'h33, 1'b1);
        lk(6'd2, 8'h10);
        wr(6'd5, 8'h11, 8'h55, 1'b0);
        inv(1'b0, 6'd5);
        lk(6'd2, 8'h10);
        wr(6'd1, 8'h12, 8'h66, 1'b0);
        inv(1'b1, 6'd0);
        for (int i = 0; i < N - 3; i++) idle();
        lk(6'd2, 8'h10);
        lk(6'd5, 8'h11);
        lk(6'd1, 8'h12);
        lk(6'd0, 8'hC9);

        // Fill, replace, round-robin wrap
        rst();
        for (int i = 0; i < N; i++) wr(6'd0, 8'(i), 8'(8'h80 + i), 1'b0);
        wr(6'd0, 8'h08, 8'h88, 1'b0);
        lk(6'd0, 8'h00);
        lk(6'd0, 8'h08);
        for (int i = 9; i <= 16; i++) wr(6'd0, 8'(i), 8'(8'h80 + i), 1'b0);
        wr(6'd0, 8'h11, 8'h91, 1'b0);
        lk(6'd0, 8'h09);
        lk(6'd0, 8'h10);
        lk(6'd0, 8'h11);

        // In-place update does not consume a replacement
        rst();
        wr(6'd3, 8'hC9, 8'h02, 1'b0);
        wr(6'd3, 8'hC9, 8'h07, 1'b0);
        lk(6'd3, 8'hC9);
        for (int i = 1; i < N; i++) wr(6'd3, 8'(8'h40 + i), 8'(i), 1'b0);
        wr(6'd3, 8'h50, 8'h77, 1'b0);
        lk(6'd3, 8'hC9);
        lk(6'd3, 8'h41);

        // Same-edge write and lookup sees the old table
        rst();
        drive(0, 1, 6'd0, 8'h20, 1, 6'd0, 8'h20, 8'h44, 0, 0, 0, 6'd0);
        lk(6'd0, 8'h20);

        // Invalidate beats a simultaneous write
        drive(0, 0, 6'd0, 8'h00, 1, 6'd0, 8'h21, 8'h45, 0, 1, 1, 6'd0);
        for (int i = 0; i < N; i++) idle();
        lk(6'd0, 8'h21);
        lk(6'd0, 8'h20);

        // Reset aborts a walk
        wr(6'd2, 8'h30, 8'h31, 1'b1);
        inv(1'b1, 6'd0);
        idle(); idle();
        rst();
        lk(6'd2, 8'h30);
        wr(6'd2, 8'h30, 8'h32, 1'b0);
        lk(6'd2, 8'h30);

        // Random traffic over a small tag space to get frequent hits and collisions
        rst();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 299) == 0,
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                  $urandom_range(0, 2) == 0, 6'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                  8'($urandom), 1'($urandom_range(0, 5) == 0),
                  $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)));
        end
        idle(); idle(); idle();

        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
